// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared encodings for the shift sequencer and its universal shift register:
//   - command opcodes (direction and bit order of a serial transfer)
//   - shift register mode selects
//   - sequencer FSM state type
// -----------------------------------------------------------------------------
package shift_seq_pkg;

   // Command opcodes: bit 1 selects receive, bit 0 selects MSB-first order
   localparam logic [1:0] OP_TX_LSB = 2'b00;
   localparam logic [1:0] OP_TX_MSB = 2'b01;
   localparam logic [1:0] OP_RX_LSB = 2'b10;
   localparam logic [1:0] OP_RX_MSB = 2'b11;

   // Shift register mode selects
   localparam logic [1:0] S_HOLD = 2'b00;
   localparam logic [1:0] S_SHR  = 2'b01;   // toward bit 0, msb_in fills the top
   localparam logic [1:0] S_SHL  = 2'b10;   // toward the MSB, lsb_in fills bit 0
   localparam logic [1:0] S_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_RESP  = 2'b10
   } state_t;

   function automatic logic op_is_tx(input logic [1:0] op);
      return ~op[1];
   endfunction

   // MSB-first transfers shift left: TX presents Q[MSB], RX fills from bit 0
   function automatic logic op_is_msb_first(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/shift_seq_ctrl_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// N-bit universal shift register: hold, shift right, shift left, parallel load.
// Ports:
//   clk      in  clock, rising edge
//   reset_n  in  asynchronous active-low reset, clears the register
//   s        in  mode select (S_HOLD / S_SHR / S_SHL / S_LOAD)
//   msb_in   in  serial fill for the top bit on a right shift
//   lsb_in   in  serial fill for bit 0 on a left shift
//   i        in  parallel load word
//   q        out register contents
// -----------------------------------------------------------------------------
module univ_shift_reg
   import shift_seq_pkg::*;
#(
   parameter int N = 8
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic [1:0]   s,
   input  logic         msb_in,
   input  logic         lsb_in,
   input  logic [N-1:0] i,
   output logic [N-1:0] q
);

   logic [N-1:0] q_d;
   logic [N-1:0] q_q;

   always_comb begin
      q_d = q_q;
      case (s)
         S_SHR:   q_d = {msb_in, q_q[N-1:1]};
         S_SHL:   q_d = {q_q[N-2:0], lsb_in};
         S_LOAD:  q_d = i;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Command-driven sequencer around one univ_shift_reg. A TX command serialises
// cmd_data onto ser_out; an RX command deserialises ser_in into rsp_data.
// Bit order is LSB- or MSB-first; every bit is paced by bit_tick. Each
// accepted command yields exactly one response unless it is aborted or reset.
// Ports:
//   clk, reset_n            clock; asynchronous active-low reset
//   cmd_valid/ready         host command handshake (ready only in IDLE)
//   cmd_op                  OP_TX_LSB / OP_TX_MSB / OP_RX_LSB / OP_RX_MSB
//   cmd_data                word to transmit (ignored for RX)
//   abort                   cancel the transfer in progress, no response
//   bit_tick                one-cycle bit strobe
//   ser_in                  serial receive data, sampled on a tick edge
//   ser_out, ser_oe         serial transmit data and its output enable
//   rsp_valid/ready         response handshake
//   rsp_data                received word (zero for TX)
//   busy                    high whenever not IDLE
// -----------------------------------------------------------------------------
module shift_seq_ctrl
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   input  logic             bit_tick,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             ser_oe,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;

   logic [1:0]       sr_mode;
   logic             sr_msb_in;
   logic             sr_lsb_in;
   logic [WIDTH-1:0] sr_q;

   univ_shift_reg #(.N(WIDTH)) u_shift_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .s       (sr_mode),
      .msb_in  (sr_msb_in),
      .lsb_in  (sr_lsb_in),
      .i       (cmd_data),
      .q       (sr_q)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      sr_mode   = S_HOLD;
      sr_msb_in = 1'b0;
      sr_lsb_in = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d    = cmd_op;
               cnt_d   = '0;
               state_d = ST_SHIFT;
               // TX words enter the register on the accept edge so bit 0 is
               // already on ser_out in the first SHIFT cycle.
               if (op_is_tx(cmd_op)) begin
                  sr_mode = S_LOAD;
               end
            end
         end

         ST_SHIFT: begin
            // abort wins over a coincident tick: nothing shifts, no response
            if (abort) begin
               state_d = ST_IDLE;
            end else if (bit_tick) begin
               sr_mode = op_is_msb_first(op_q) ? S_SHL : S_SHR;
               // TX back-fills zeros; RX fills with the sampled line
               if (!op_is_tx(op_q)) begin
                  sr_msb_in = ser_in;
                  sr_lsb_in = ser_in;
               end
               if (cnt_q == LAST_BIT) begin
                  state_d = ST_RESP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_TX_LSB;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign ser_oe    = (state_q == ST_SHIFT) && op_is_tx(op_q);
   assign ser_out   = ser_oe &&
                      (op_is_msb_first(op_q) ? sr_q[WIDTH-1] : sr_q[0]);
   assign rsp_data  = (rsp_valid && !op_is_tx(op_q)) ? sr_q : '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Directed bench for shift_seq_ctrl (WIDTH=8). Inputs change and outputs are
// sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;
   import shift_seq_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       abort;
   logic       bit_tick;
   logic       ser_in;
   logic       ser_out;
   logic       ser_oe;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   shift_seq_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .abort     (abort),
      .bit_tick  (bit_tick),
      .ser_in    (ser_in),
      .ser_out   (ser_out),
      .ser_oe    (ser_oe),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer a command with bit_tick high in the accept cycle (must be ignored)
   task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      bit_tick  = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         step();
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      bit_tick  = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_ready", 32'(cmd_ready), 32'd0);
   endtask

   // exp_bits[k] is the k-th bit expected on the line
   task automatic run_tx(input string tag, input logic [1:0] op, input logic [7:0] data,
                         input int period, input logic [7:0] exp_bits);
      send_cmd(op, data);
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < period; c++) begin
            bit_tick = (c == period - 1);
            chk({tag, "_oe"}, 32'(ser_oe), 32'd1);
            chk({tag, "_bit"}, 32'(ser_out), 32'(exp_bits[k]));
            step();
         end
      end
      bit_tick = 1'b0;
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'h00);
      chk({tag, "_oe_off"}, 32'(ser_oe), 32'd0);
      chk({tag, "_out_off"}, 32'(ser_out), 32'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   // stream[k] is the k-th bit on the line; the line holds the inverted bit
   // between ticks so only tick-cycle sampling yields the right word
   task automatic run_rx(input string tag, input logic [1:0] op, input logic [7:0] stream,
                         input int period, input logic [7:0] exp_word, input logic ack);
      send_cmd(op, 8'hA5);
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < period; c++) begin
            bit_tick = (c == period - 1);
            ser_in   = (c == period - 1) ? stream[k] : ~stream[k];
            chk({tag, "_oe"}, 32'(ser_oe), 32'd0);
            step();
         end
      end
      bit_tick = 1'b0;
      ser_in   = 1'b0;
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_word));
      if (ack) begin
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         chk({tag, "_idle"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'h00;
      abort     = 1'b0;
      bit_tick  = 1'b0;
      ser_in    = 1'b0;
      rsp_ready = 1'b0;

      step();
      step();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h00);
      chk("rst_ser_oe", 32'(ser_oe), 32'd0);
      chk("rst_ser_out", 32'(ser_out), 32'd0);
      reset_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);

      // TX LSB-first 0xC1, tick every cycle: 1,0,0,0,0,0,1,1
      run_tx("tx_lsb", OP_TX_LSB, 8'hC1, 1, 8'b1100_0001);
      // TX MSB-first 0xC1, tick every 3rd cycle: 1,1,0,0,0,0,0,1
      run_tx("tx_msb", OP_TX_MSB, 8'hC1, 3, 8'b1000_0011);
      // RX LSB-first of 1,1,0,0,0,0,0,1 -> 0x83
      run_rx("rx_lsb", OP_RX_LSB, 8'b1000_0011, 1, 8'h83, 1'b1);
      // RX MSB-first of same stream, slow ticks, response held back
      run_rx("rx_msb", OP_RX_MSB, 8'b1000_0011, 2, 8'hC1, 1'b0);

      // Stall the response 5 cycles; tick and abort in RESP must be ignored
      bit_tick = 1'b1;
      abort    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_rsp_data", 32'(rsp_data), 32'hC1);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      bit_tick = 1'b0;
      abort    = 1'b0;

      // Command offered during the handshake cycle is taken one cycle later
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = OP_TX_LSB;
      cmd_data  = 8'hC1;
      step();
      rsp_ready = 1'b0;
      chk("hs_idle_ready", 32'(cmd_ready), 32'd1);
      chk("hs_idle_busy", 32'(busy), 32'd0);
      chk("hs_rsp_gone", 32'(rsp_valid), 32'd0);
      step();
      cmd_valid = 1'b0;
      chk("next_accept_busy", 32'(busy), 32'd1);
      chk("next_tx_oe", 32'(ser_oe), 32'd1);
      chk("next_tx_bit0", 32'(ser_out), 32'd1);

      // Three ticks then abort (with a coincident tick)
      bit_tick = 1'b1;
      step();
      chk("abort_bit1", 32'(ser_out), 32'd0);
      step();
      chk("abort_bit2", 32'(ser_out), 32'd0);
      step();
      chk("abort_bit3", 32'(ser_out), 32'd0);
      abort = 1'b1;
      step();
      abort    = 1'b0;
      bit_tick = 1'b0;
      chk("abort_idle", 32'(busy), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      chk("abort_oe", 32'(ser_oe), 32'd0);
      chk("abort_out", 32'(ser_out), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // TX after abort starts cleanly from the new word
      run_tx("tx_after_abort", OP_TX_MSB, 8'h5A, 1, 8'b0101_1010);

      // Reset pulse in the middle of an RX
      send_cmd(OP_RX_LSB, 8'h00);
      bit_tick = 1'b1;
      ser_in   = 1'b1;
      step();
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_oe", 32'(ser_oe), 32'd0);
      bit_tick = 1'b0;
      ser_in   = 1'b0;
      step();
      #2;
      reset_n = 1'b1;
      step();
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      run_rx("rx_after_rst", OP_RX_LSB, 8'b1000_0011, 1, 8'h83, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
